text_pixel_pipeline: RTL and testbench

Pixel-domain text renderer that consumes the VRAM and control register written over the AXI4-Lite slave and produces 4-bit-per-channel RGB for the HDMI encoder. It runs an 80×30 character grid with an 8×16 font on a 640×480 raster. Each pixel position from the VGA timing generator becomes a VRAM word fetch, then a font-ROM fetch, then a colour select. Syncs and data-enable are delayed to match the pipeline so they stay aligned with the pixel data.

---
 rtl/text_pixel_pipeline.sv | 175 +++++++++++++++++
 tb/tb_text_pixel_pipeline.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel pipeline: drawX/drawY -> VRAM word -> font ROM row -> RGB, four cycles of latency.
// Optional macro TEXT_BLINK_EN: inverse-video characters blink with a 64-frame period.

module text_pixel_pipeline #(
  parameter int H_CHARS   = 80,
  parameter int V_CHARS   = 30,
  parameter int CTRL_WORD = 600
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        vde_in,
  output logic [9:0]  vram_addr,
  input  logic [31:0] vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [31:0] ctrl_reg,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vde_out
);

  // The control word must sit above the character cells in VRAM.
  generate
    if (CTRL_WORD * 4 < H_CHARS * V_CHARS) begin : g_cfg_check
      $error("text_pixel_pipeline: CTRL_WORD overlaps the character cells");
    end
  endgenerate

  logic [11:0] char_index;
  assign char_index = 12'(32'(drawY[9:4]) * H_CHARS + 32'(drawX[9:3]));

  logic [1:0] s1_lane, s2_lane;
  logic [2:0] s1_col, s2_col, s3_col;
  logic [3:0] s1_row, s2_row;
  logic       s1_hs, s1_vs, s1_de, s1_live;
  logic       s2_hs, s2_vs, s2_de, s2_live;
  logic       s3_hs, s3_vs, s3_de, s3_inv;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vram_addr <= '0;
      s1_lane   <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_de     <= 1'b0;
      s1_live   <= 1'b0;
    end else begin
      vram_addr <= vde_in ? char_index[11:2] : '0;
      s1_lane   <= char_index[1:0];
      s1_col    <= drawX[2:0];
      s1_row    <= drawY[3:0];
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_de     <= vde_in;
      s1_live   <= 1'b1;
    end
  end

  // The VRAM's own read register is the data half of this stage; the rest travels alongside.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      s2_lane <= '0;
      s2_col  <= '0;
      s2_row  <= '0;
      s2_hs   <= 1'b1;
      s2_vs   <= 1'b1;
      s2_de   <= 1'b0;
      s2_live <= 1'b0;
    end else begin
      s2_lane <= s1_lane;
      s2_col  <= s1_col;
      s2_row  <= s1_row;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_de   <= s1_de;
      s2_live <= s1_live;
    end
  end

  logic [7:0] char_byte;
  assign char_byte = vram_rdata[8*s2_lane +: 8];
  assign font_addr = s2_live ? {char_byte[6:0], s2_row} : '0;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      s3_col <= '0;
      s3_inv <= 1'b0;
      s3_hs  <= 1'b1;
      s3_vs  <= 1'b1;
      s3_de  <= 1'b0;
    end else begin
      s3_col <= s2_col;
      s3_inv <= char_byte[7];
      s3_hs  <= s2_hs;
      s3_vs  <= s2_vs;
      s3_de  <= s2_de;
    end
  end

  logic vsync_prev;
  logic vsync_fall;

  always_ff @(posedge pixel_clk) begin
    vsync_prev <= vsync_in;
  end

  assign vsync_fall = vsync_prev & ~vsync_in;

  // FG in [23:12], BG in [11:0], each as R/G/B nibbles; only refreshed at frame start.
  logic [23:0] colour_latch;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      colour_latch <= '0;
    end else if (vsync_fall) begin
      colour_latch <= ctrl_reg[24:1];
    end
  end

  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_reg[31:25], ctrl_reg[0]};

  logic invert_eff;

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_count;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (vsync_fall) begin
      frame_count <= frame_count + 6'd1;
    end
  end

  assign invert_eff = s3_inv & frame_count[5];
`else
  assign invert_eff = s3_inv;
`endif

  logic pix_on;
  assign pix_on = font_data[3'd7 - s3_col] ^ invert_eff;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      vde_out   <= 1'b0;
    end else begin
      hsync_out <= s3_hs;
      vsync_out <= s3_vs;
      vde_out   <= s3_de;
      if (!s3_de) begin
        {red, green, blue} <= '0;
      end else if (pix_on) begin
        {red, green, blue} <= colour_latch[23:12];
      end else begin
        {red, green, blue} <= colour_latch[11:0];
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Self-checking bench for text_pixel_pipeline: directed cases plus randomized raster traffic
// compared against a per-cycle behavioural model of the text renderer.

module tb_text_pixel_pipeline;

  localparam int H_CHARS = 80;
  localparam int MAXC    = 8192;
  localparam logic [31:0] GLYPH_CTRL = 32'h01FF_E002;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY;
  logic        hsync_in, vsync_in, vde_in;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [31:0] ctrl_reg;
  logic [3:0]  red, green, blue;
  logic        hsync_out, vsync_out, vde_out;

  text_pixel_pipeline dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .drawX      (drawX),
    .drawY      (drawY),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .vde_in     (vde_in),
    .vram_addr  (vram_addr),
    .vram_rdata (vram_rdata),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .ctrl_reg   (ctrl_reg),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .vde_out    (vde_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Synchronous-read memories standing in for the VRAM port and the font ROM.
  logic [31:0] vram_mem [1024];
  logic [7:0]  font_mem [2048];

  always @(posedge pixel_clk) begin
    vram_rdata <= vram_mem[vram_addr];
    font_data  <= font_mem[font_addr];
  end

  // Input history indexed by the clock edge that samples it, plus model state after each edge.
  int          h_x [MAXC];
  int          h_y [MAXC];
  bit          h_hs [MAXC];
  bit          h_vs [MAXC];
  bit          h_de [MAXC];
  bit          h_rst [MAXC];
  logic [31:0] latch_after [MAXC];
  int          count_after [MAXC];

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit rst_window(input int e);
    for (int k = e - 3; k <= e; k++) begin
      if (k < 1 || h_rst[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] char_at(input int x, input int y);
    int idx;
    logic [31:0] word;
    idx  = (y / 16) * H_CHARS + x / 8;
    word = vram_mem[idx / 4];
    return word[8*(idx % 4) +: 8];
  endfunction

  function automatic logic [11:0] model_rgb(input int e);
    int x, y;
    logic [7:0] chr, row;
    logic [31:0] col;
    bit inv, on;
    if (rst_window(e) || !h_de[e-3]) return 12'h000;
    x   = h_x[e-3];
    y   = h_y[e-3];
    chr = char_at(x, y);
    row = font_mem[int'(chr[6:0]) * 16 + y % 16];
    inv = chr[7];
`ifdef TEXT_BLINK_EN
    inv = inv && (count_after[e-1] >= 32);
`endif
    on  = row[7 - x % 8] ^ inv;
    col = latch_after[e-1];
    return on ? {col[24:21], col[20:17], col[16:13]} : {col[12:9], col[8:5], col[4:1]};
  endfunction

  task automatic checkCycle(input int e);
    logic [31:0] exp_sync, exp_addr;
    logic [7:0] chr;
    checkOutput("rgb", 32'({red, green, blue}), 32'(model_rgb(e)));
    exp_sync = rst_window(e) ? 32'b110 : 32'({h_hs[e-3], h_vs[e-3], h_de[e-3]});
    checkOutput("syncs", 32'({hsync_out, vsync_out, vde_out}), exp_sync);
    exp_addr = (h_rst[e] || !h_de[e]) ? 32'd0 : 32'(((h_y[e] / 16) * H_CHARS + h_x[e] / 8) / 4);
    checkOutput("vram_addr", 32'(vram_addr), exp_addr);
    if (h_rst[e] || h_rst[e-1]) begin
      checkOutput("font_addr_rst", 32'(font_addr), 32'd0);
    end else if (h_de[e-1]) begin
      chr = char_at(h_x[e-1], h_y[e-1]);
      checkOutput("font_addr", 32'(font_addr), 32'({chr[6:0], 4'(h_y[e-1] % 16)}));
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit hs, input bit vs,
                               input bit de, input bit rst, input logic [31:0] ctrl);
    int e;
    e = cyc + 1;
    if (e >= MAXC) begin
      $display("[TB] FAIL cycle_budget: got %0d cycles, limit %0d", e, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    drawX    = 10'(x);
    drawY    = 10'(y);
    hsync_in = hs;
    vsync_in = vs;
    vde_in   = de;
    reset    = rst;
    ctrl_reg = ctrl;
    h_x[e] = x; h_y[e] = y; h_hs[e] = hs; h_vs[e] = vs; h_de[e] = de; h_rst[e] = rst;
    @(posedge pixel_clk);
    cyc = e;
    if (rst) begin
      latch_after[e] = 32'd0;
      count_after[e] = 0;
    end else if (h_vs[e-1] && !vs) begin
      latch_after[e] = ctrl;
      count_after[e] = (count_after[e-1] + 1) % 64;
    end else begin
      latch_after[e] = latch_after[e-1];
      count_after[e] = count_after[e-1];
    end
    @(negedge pixel_clk);
    checkCycle(e);
  endtask

  task automatic idle(input int n, input bit vs, input logic [31:0] ctrl);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b1, vs, 1'b0, 1'b0, ctrl);
  endtask

  // Sweeps the first glyph row and checks each pixel against the 0x18 pattern.
  task automatic glyphSweep(input string tag, input bit inverted);
    logic [11:0] exp;
    bit on;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i < 8 ? i : 0, 0, 1'b1, 1'b1, i < 8, 1'b0, GLYPH_CTRL);
      if (i >= 3) begin
        on  = ((i - 3) == 3 || (i - 3) == 4) ^ inverted;
        exp = on ? 12'hFFF : 12'h001;
        checkOutput(tag, 32'({red, green, blue}), 32'(exp));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ctrl_cur, new_ctrl;
    bit inv_active;
    for (int i = 0; i < 1024; i++) vram_mem[i] = $urandom;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    h_rst[0] = 1'b1; h_vs[0] = 1'b1; h_de[0] = 1'b0;
    latch_after[0] = 32'd0; count_after[0] = 0;

    // Reset with arbitrary inputs, including a vsync fall that must not load the latch.
    for (int i = 0; i < 3; i++)
      applyStimulus($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom),
                    i == 0, 1'($urandom), 1'b1, $urandom);
    idle(4, 1'b0, 32'h0);
    checkOutput("latch_after_reset", 32'({red, green, blue}), 32'd0);
    idle(2, 1'b1, GLYPH_CTRL);
    idle(2, 1'b0, GLYPH_CTRL);
    idle(4, 1'b1, GLYPH_CTRL);

    vram_mem[40] = 32'h335A_7711;
    applyStimulus(17, 35, 1'b1, 1'b1, 1'b1, 1'b0, GLYPH_CTRL);
    checkOutput("addr_40", 32'(vram_addr), 32'd40);
    idle(1, 1'b1, GLYPH_CTRL);
    checkOutput("lane2_font_addr", 32'(font_addr), 32'h5A3);
    idle(4, 1'b1, GLYPH_CTRL);

    vram_mem[0] = 32'h0000_0041;
    font_mem[11'h410] = 8'h18;
    idle(3, 1'b1, GLYPH_CTRL);
    glyphSweep("glyph", 1'b0);

    vram_mem[0] = 32'h0000_00C1;
    idle(3, 1'b1, GLYPH_CTRL);
`ifdef TEXT_BLINK_EN
    inv_active = count_after[cyc] >= 32;
`else
    inv_active = 1'b1;
`endif
    glyphSweep("glyph_invert", inv_active);

    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(0, 799), $urandom_range(0, 524), 1'b1, 1'b1, 1'b0, 1'b0, GLYPH_CTRL);
      checkOutput("blank_vram_addr", 32'(vram_addr), 32'd0);
      if (i >= 3) checkOutput("blank_rgb", 32'({red, green, blue}), 32'd0);
    end

    // Colour latch: ctrl changes mid-frame, takes effect only the cycle after vsync falls.
    vram_mem[0] = 32'h0000_0041;
    idle(3, 1'b1, GLYPH_CTRL);
    new_ctrl = $urandom;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(i % 8, 0, 1'b1, !(i == 15 || i == 16), 1'b1, 1'b0, i >= 5 ? new_ctrl : GLYPH_CTRL);
      if (i == 15) checkOutput("latch_hold", 32'({red, green, blue}), 32'h0FFF);
      if (i == 16) checkOutput("latch_new", 32'({red, green, blue}),
                               32'({new_ctrl[12:9], new_ctrl[8:5], new_ctrl[4:1]}));
    end
    ctrl_cur = new_ctrl;

    // Randomized raster traffic with occasional frame starts and one mid-line reset.
    for (int i = 0; i < 1500; i++) begin
      bit de, vs, rst;
      int x, y;
      de  = ($urandom % 8) != 0;
      x   = de ? $urandom_range(0, 639) : $urandom_range(0, 799);
      y   = de ? $urandom_range(0, 479) : $urandom_range(0, 524);
      vs  = !((i % 300) == 150 || (i % 300) == 151);
      rst = (i == 700 || i == 701);
      if ((i % 47) == 0) ctrl_cur = $urandom;
      applyStimulus(x, y, 1'($urandom), vs, de, rst, ctrl_cur);
    end
    idle(4, 1'b1, ctrl_cur);

`ifdef TEXT_BLINK_EN
    vram_mem[0] = 32'h0000_00C1;
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, GLYPH_CTRL);
    idle(4, 1'b1, GLYPH_CTRL);
    for (int k = 1; k <= 64; k++) begin
      for (int j = 0; j < 15; j++) begin
        applyStimulus((j >= 4 && j < 12) ? j - 4 : 0, 0, 1'b1, j >= 2,
                      (j >= 4 && j < 12), 1'b0, GLYPH_CTRL);
        if (j == 10)
          checkOutput("blink_pixel3", 32'({red, green, blue}),
                      (k >= 32 && k < 64) ? 32'h001 : 32'hFFF);
      end
    end
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
